lr_shift_deser: RTL and testbench
=================================

Name: lr_shift_deser

Overview:
Receiving end of the LR shift-register serial path. Captures a serial bit stream shifted out of an LR shift register, in either shift direction, and rebuilds the parallel word. The completed word is presented on a valid/ready output buffer. Sits between the serial link and the parallel consumer logic.

Parameters:
W, 8, data word width in bits (min 2)

Ports:
clk    in   1   single clock, all logic on rising edge
rst    in   1   synchronous, active-high reset
Start  in   1   frame start: arms reception, clears bit count, latches Dir
Dir    in   1   source shift direction: 1 = left shift (MSB first), 0 = right shift (LSB first)
Si     in   1   serial data bit
Sv     in   1   Si qualifier; bit is sampled only when Sv=1
Ready  in   1   consumer accepts Out
Out    out  W   received word
Valid  out  1   Out holds an unconsumed word
Busy   out  1   frame in progress
Overrun out 1   sticky: a completed word was dropped
Perr   out  1   parity error flag for the word on Out (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): state IDLE; Out=0, Valid=0, Busy=0, Overrun=0, Perr=0; bit count=0; shift reg=0; latched dir=0. Reset mid-frame discards the partial word and the buffered word.
- States: IDLE, RECV.
- IDLE: Busy=0. Sv ignored. Start=1 -> RECV, count=0, dir_q<=Dir, shift reg cleared, Overrun cleared.
- Start cycle only arms. Si/Sv in the Start cycle are not captured.
- RECV: Busy=1. Dir changes are ignored (dir_q only).
  - Each Sv=1 cycle, dir_q=1: sh <= {sh[W-2:0], Si}.
  - Each Sv=1 cycle, dir_q=0: sh <= {Si, sh[W-1:1]}.
  - count increments per sampled bit.
  - Sv=0 cycles: hold, no timeout.
- Completion: the edge sampling bit W (count==W-1 and Sv=1) completes the frame; state -> IDLE. Valid/Out update at that same edge, so Valid is high the cycle after the last bit (latency 1 clk).
- Start=1 in RECV: abort; restart as from IDLE (count=0, relatch Dir, clear Overrun). Start overrides a simultaneous completing bit; that word is discarded, no Valid.
- Output buffer:
  - Valid=1 holds Out/Perr stable until Ready=1 at an edge; Valid falls after that edge.
  - Completion with Valid=0: load Out, Valid<=1.
  - Completion with Valid=1 and Ready=1 in the same cycle: load new word, Valid stays 1 (back-to-back, no bubble).
  - Completion with Valid=1 and Ready=0: new word dropped, Out unchanged, Overrun<=1.
  - Overrun stays set until the next Start or rst.
  - Ready with Valid=0 has no effect.

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - RECV samples W+1 bits; the final bit is a parity bit, always last regardless of direction, and is not shifted into sh.
  - Completion occurs on bit W+1.
  - Perr = 1 if XOR(data bits, parity bit) != 0 (even parity). Perr loads and holds with Out under the same rules.
- Not defined:
  - W bits per frame; Perr tied 0.
  - Port list identical in both builds.

Test Plan:
- rst=1 one cycle -> all outputs 0, Busy=0; Sv pulses in IDLE -> no state change.
- Start, Dir=1, bits 1,0,1,1,0,1,0,0 on consecutive Sv cycles -> Out=0xB4, Valid=1 the cycle after the 8th bit; Ready=1 one cycle -> Valid=0.
- Start, Dir=0, same bit sequence -> Out=0x2D. Insert Sv=0 gaps between bits -> same result, Busy=1 throughout.
- Abort/overrun:
  - Start after 4 bits, then 8 fresh bits with Dir=1 of 0xFF -> Out=0xFF.
  - A second frame 0x0F completes while Ready=0 -> Out stays 0xFF, Overrun=1.
  - Next Start -> Overrun=0.
- Back-to-back: Ready=1 on the exact cycle the 2nd frame (0x55, Dir=1) completes -> Out=0x55, Valid never drops.
- PARITY_CHECK_EN, Dir=1:
  - Data 0xB4 (four 1s) with parity bit 0 -> Perr=0.
  - Same data with parity bit 1 -> Perr=1, Out=0xB4.

Source files
------------

// File: rtl/lr_shift_deser.sv
// LR shift-register serial receiver with valid/ready output buffer.
// Optional parity check enabled by defining PARITY_CHECK_EN.
module lr_shift_deser #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic         Dir,
  input  logic         Si,
  input  logic         Sv,
  input  logic         Ready,
  output logic [W-1:0] Out,
  output logic         Valid,
  output logic         Busy,
  output logic         Overrun,
  output logic         Perr
);

  localparam int unsigned CW = $clog2(W + 1);
`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] LAST = CW'(W);
`else
  localparam logic [CW-1:0] LAST = CW'(W - 1);
`endif

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic [W-1:0]  r_sh;
  logic [W-1:0]  r_out;
  logic          r_valid;
  logic          r_overrun;
  logic          r_perr;

  logic          w_sample;
  logic          w_done;
  logic [W-1:0]  w_shifted;
  logic [W-1:0]  w_word;
  logic          w_perr;
  logic          w_load;

  // Start always wins over a sampled bit, so a completing bit in a Start cycle is discarded.
  assign w_sample  = (r_state == RECV) && Sv && !Start;
  assign w_done    = w_sample && (r_cnt == LAST);
  assign w_shifted = r_dir ? {r_sh[W-2:0], Si} : {Si, r_sh[W-1:1]};
  assign w_load    = w_done && (!r_valid || Ready);

`ifdef PARITY_CHECK_EN
  // The parity bit arrives last and is never shifted into the data register.
  assign w_word = r_sh;
  assign w_perr = (^r_sh) ^ Si;
`else
  assign w_word = w_shifted;
  assign w_perr = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (Start) w_state_nxt = RECV;
      RECV: begin
        if (Start)       w_state_nxt = RECV;
        else if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_sh      <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (Start) begin
        r_cnt <= '0;
        r_dir <= Dir;
        r_sh  <= '0;
      end else if (w_sample) begin
        r_cnt <= r_cnt + 1'b1;
`ifdef PARITY_CHECK_EN
        if (r_cnt != LAST) r_sh <= w_shifted;
`else
        r_sh <= w_shifted;
`endif
      end

      if (w_load) begin
        r_out   <= w_word;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (r_valid && Ready) begin
        r_valid <= 1'b0;
      end

      if (Start)
        r_overrun <= 1'b0;
      else if (w_done && r_valid && !Ready)
        r_overrun <= 1'b1;
    end
  end

  assign Out     = r_out;
  assign Valid   = r_valid;
  assign Busy    = (r_state == RECV);
  assign Overrun = r_overrun;
`ifdef PARITY_CHECK_EN
  assign Perr    = r_perr;
`else
  assign Perr    = 1'b0;
`endif

endmodule

// File: tb/tb_lr_shift_deser.sv
module tb_lr_shift_deser;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         Start;
  logic         Dir;
  logic         Si;
  logic         Sv;
  logic         Ready;
  logic [W-1:0] Out;
  logic         Valid;
  logic         Busy;
  logic         Overrun;
  logic         Perr;

  int n_cmp;
  int n_err;

  lr_shift_deser #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .Start   (Start),
    .Dir     (Dir),
    .Si      (Si),
    .Sv      (Sv),
    .Ready   (Ready),
    .Out     (Out),
    .Valid   (Valid),
    .Busy    (Busy),
    .Overrun (Overrun),
    .Perr    (Perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic d);
    Start = 1'b1;
    Dir   = d;
    tick();
    Start = 1'b0;
    Dir   = ~d;
  endtask

  // seq[W-1] is the first bit on the wire; p is the trailing parity bit when enabled.
  task automatic send(input logic [W-1:0] seq, input bit gap, input logic p, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      Si = seq[i];
      Sv = 1'b1;
`ifndef PARITY_CHECK_EN
      if (i == 0) Ready = rdy_last;
`endif
      tick();
      Sv    = 1'b0;
      Ready = 1'b0;
      Si    = 1'b0;
      if (gap && i > 0) begin
        tick();
        chk("busy_gap", {31'b0, Busy}, 32'd1);
      end
    end
`ifdef PARITY_CHECK_EN
    Si    = p;
    Sv    = 1'b1;
    Ready = rdy_last;
    tick();
    Sv    = 1'b0;
    Ready = 1'b0;
    Si    = 1'b0;
`else
    if (p === 1'bx) $display("parity argument unknown");
`endif
  endtask

  task automatic consume();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; Start = 1'b0; Dir = 1'b0; Si = 1'b0; Sv = 1'b0; Ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out",     {24'b0, Out},     32'h0);
    chk("rst_valid",   {31'b0, Valid},   32'd0);
    chk("rst_busy",    {31'b0, Busy},    32'd0);
    chk("rst_overrun", {31'b0, Overrun}, 32'd0);
    chk("rst_perr",    {31'b0, Perr},    32'd0);

    // Sv activity while idle must not start or fill a frame
    Si = 1'b1; Sv = 1'b1;
    repeat (3) tick();
    Sv = 1'b0; Si = 1'b0;
    chk("idle_busy",  {31'b0, Busy},  32'd0);
    chk("idle_valid", {31'b0, Valid}, 32'd0);

    // MSB-first: bits 1,0,1,1,0,1,0,0
    start_frame(1'b1);
    chk("armed_busy",  {31'b0, Busy},  32'd1);
    send(8'hB4, 1'b0, 1'b0, 1'b0);
    chk("l_valid", {31'b0, Valid}, 32'd1);
    chk("l_out",   {24'b0, Out},   32'hB4);
    chk("l_busy",  {31'b0, Busy},  32'd0);
    chk("l_perr",  {31'b0, Perr},  32'd0);
    consume();
    chk("l_consumed", {31'b0, Valid}, 32'd0);
    chk("l_out_hold", {24'b0, Out},   32'hB4);

    // LSB-first with idle gaps between bits
    start_frame(1'b0);
    send(8'hB4, 1'b1, 1'b0, 1'b0);
    chk("r_valid", {31'b0, Valid}, 32'd1);
    chk("r_out",   {24'b0, Out},   32'h2D);
    consume();
    chk("r_consumed", {31'b0, Valid}, 32'd0);

    // Start coinciding with what would be the last data bit aborts it
    start_frame(1'b1);
    for (int i = 0; i < int'(W) - 1; i++) begin
      Si = 1'b1; Sv = 1'b1; tick();
    end
    Start = 1'b1; Dir = 1'b1; Si = 1'b1; Sv = 1'b1;
    tick();
    Start = 1'b0; Sv = 1'b0;
    chk("abortlast_valid", {31'b0, Valid}, 32'd0);
    chk("abortlast_busy",  {31'b0, Busy},  32'd1);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("after_abortlast_out", {24'b0, Out}, 32'hFF);
    consume();

    // Abort after 4 bits, then a fresh frame
    start_frame(1'b1);
    for (int i = 0; i < 4; i++) begin
      Si = 1'b0; Sv = 1'b1; tick();
    end
    Sv = 1'b0;
    start_frame(1'b1);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("abort_out",   {24'b0, Out},   32'hFF);
    chk("abort_valid", {31'b0, Valid}, 32'd1);

    // Second frame completes while the buffer is still full
    start_frame(1'b1);
    send(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("ovr_out",   {24'b0, Out},     32'hFF);
    chk("ovr_valid", {31'b0, Valid},   32'd1);
    chk("ovr_flag",  {31'b0, Overrun}, 32'd1);
    tick();
    chk("ovr_sticky", {31'b0, Overrun}, 32'd1);
    start_frame(1'b1);
    chk("ovr_clear", {31'b0, Overrun}, 32'd0);

    // Back-to-back: Ready on the completing cycle replaces the word with no bubble
    chk("b2b_pre_valid", {31'b0, Valid}, 32'd1);
    send(8'h55, 1'b0, 1'b0, 1'b1);
    chk("b2b_out",     {24'b0, Out},     32'h55);
    chk("b2b_valid",   {31'b0, Valid},   32'd1);
    chk("b2b_overrun", {31'b0, Overrun}, 32'd0);
    consume();
    chk("b2b_consumed", {31'b0, Valid}, 32'd0);

`ifdef PARITY_CHECK_EN
    start_frame(1'b1);
    send(8'hB4, 1'b0, 1'b0, 1'b0);
    chk("par_ok_out",  {24'b0, Out},  32'hB4);
    chk("par_ok_perr", {31'b0, Perr}, 32'd0);
    consume();
    start_frame(1'b1);
    send(8'hB4, 1'b0, 1'b1, 1'b0);
    chk("par_bad_out",  {24'b0, Out},  32'hB4);
    chk("par_bad_perr", {31'b0, Perr}, 32'd1);
    consume();
`endif

    // Reset mid-frame clears everything
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      Si = 1'b1; Sv = 1'b1; tick();
    end
    Sv = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy",  {31'b0, Busy},  32'd0);
    chk("midrst_out",   {24'b0, Out},   32'h0);
    chk("midrst_valid", {31'b0, Valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
